flash_spi_arbiter: RTL
======================

// Module: flash_spi_arbiter
// PURPOSE
//  SPI master and two-port arbiter for the external NOR flash, supporting the 03h READ command only.
//  Accepts 24-bit word-read requests from two requesters (port 0 = IFU fetch, port 1 = LSU load).
//  Round-robin arbitration. Generates sck/ss/mosi, shifts in 32 miso bits and returns the word.
//  Sits between the core-side request ports and the flash pins, so the flash sees one transaction at a time.
// PARAMETERS
//  SCK_DIV  1  sck half-period in clock cycles (>=1); sck frequency = clock / (2*SCK_DIV)
//  CS_GAP   2  minimum clock cycles ss stays high between transactions (>=1)
// PORTS
//  clock        in   1   system clock; all logic on posedge
//  reset_n      in   1   asynchronous, active-low reset
//  req_valid    in   2   per-port read request
//  req_addr0    in   24  port-0 byte address
//  req_addr1    in   24  port-1 byte address
//  req_ready    out  2   per-port accept; request taken when req_valid[i]&&req_ready[i]
//  resp_valid   out  2   per-port 1-cycle pulse: resp_data is valid
//  resp_data    out  32  read word; first miso bit received is in bit 31
//  busy         out  1   high from accept until the CS_GAP period ends
//  spi_sck      out  1   flash clock, idles low (mode 0)
//  spi_ss       out  1   flash chip select, active low
//  spi_mosi     out  1   command/address bits, MSB first
//  spi_miso     in   1   flash data
// BEHAVIOUR
//  Reset (async, reset_n=0): spi_ss=1, spi_sck=0, spi_mosi=0, req_ready=0, resp_valid=0,
//   resp_data=0, busy=0. Arbiter priority pointer points to port 0. Reset mid-transfer aborts with no response.
//  States:
//   IDLE  req_ready[i]=1 only for the granted port, and only when that port's req_valid is high.
//         Grant goes to the single requester, or to the port != last served when both request.
//         Accept at cycle T: latch {8'h03, addr} into a 32b shift reg, record port -> SHIFT.
//   SHIFT entered at T+1: ss=0, sck=0, mosi=shift[31].
//         A half-period counter toggles sck every SCK_DIV clocks.
//         Sck cycle n (1..63) rises at T+1+(2n-1)*SCK_DIV and falls at T+1+2n*SCK_DIV.
//         mosi advances to the next bit on each falling edge for n=1..31.
//         mosi=0 after all 32 cmd/addr bits have been sent.
//         miso is sampled on the clock edge where sck falls, for n=32..63.
//         The sample is shifted into rdata LSB-first-in, so the sample at n=32 ends in bit 31.
//         At the fall of cycle 63 -> RESP. The 64th rising edge is never issued.
//   RESP  one cycle at T+2+126*SCK_DIV: ss=1, sck=0, resp_valid[port]=1, resp_data=word.
//         The rotating pointer updates to favour the other port -> GAP.
//   GAP   ss held high for CS_GAP clocks in total, counting the RESP cycle; then -> IDLE.
//  Latency accept->resp_valid = 1+126*SCK_DIV cycles. One outstanding transaction; no pipelining.
//  resp_data holds its value until the next RESP. resp_valid does not wait for a consumer (no backpressure).
//  req_addr bits are sent unmodified; alignment is the requester's responsibility.
//  busy = (state != IDLE).
//  Glitch-free outputs: spi_sck, spi_ss and spi_mosi are driven directly from flops.
//  A req_valid drop before acceptance is legal and simply withdraws the request.
//  Simultaneous accept and reset: reset wins.
// TESTING
//  1 reset_n=0 during SHIFT -> ss=1 and sck=0 immediately (async); no resp_valid after release.
//  2 port0 read at 0x000010, flash word 0xDEADBEEF, SCK_DIV=1
//    -> mosi = 03h,000010h MSB first; resp_valid[0] at T+127; resp_data=0xDEADBEEF.
//  3 SCK_DIV=3, addr 0xABCDE4, flash word 0x12345678
//    -> each sck phase lasts 3 clocks; resp at T+379 with 0x12345678.
//  4 both ports request continuously -> grants alternate 0,1,0,1.
//    ss high >= CS_GAP clocks between frames; each port's data is correct.
//  5 port1 only, with req_valid held -> back-to-back reads; exactly 63 sck rising edges per frame.
//  6 req_valid[0] pulsed for 1 cycle while busy -> not accepted, no response.

Source files
------------

// File: rtl/flash_spi_arbiter.sv
// Two-port round-robin arbiter and mode-0 SPI master for NOR flash 03h reads.
// One 32-bit word per transaction; the flash sees one frame at a time.
module flash_spi_arbiter #(
    parameter int SCK_DIV = 1,
    parameter int CS_GAP  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [23:0] req_addr0,
    input  logic [23:0] req_addr1,
    output logic [1:0]  req_ready,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam int HW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int GW = $clog2(CS_GAP + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(SCK_DIV - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(CS_GAP - 1);
    localparam logic [7:0]    CMD_READ = 8'h03;
    localparam logic [5:0]    LAST_TX  = 6'd31;
    localparam logic [5:0]    LAST_RX  = 6'd62;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESP,
        GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [HW-1:0] half_cnt;
    logic [5:0]    fall_cnt;
    logic [GW-1:0] gap_cnt;
    logic [30:0]   tx_sr;
    logic [30:0]   rx_sr;
    logic          port;
    logic          ptr;
    logic          grant;
    logic          accept;
    logic          tick;
    logic          fall;
    logic          last_fall;

    assign tick      = (state == SHIFT) && (half_cnt == H_LAST);
    assign fall      = tick && spi_sck;
    assign last_fall = fall && (fall_cnt == LAST_RX);

    // ptr names the port favoured when both request
    always_comb begin
        grant = ptr;
        unique case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ptr;
        endcase
    end

    assign accept = (state == IDLE) && req_valid[grant];

    always_comb begin
        req_ready = 2'b00;
        if (reset_n && accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign resp_valid = (state == RESP) ? (port ? 2'b10 : 2'b01) : 2'b00;
    assign busy       = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_fall) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = (CS_GAP > 1) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_cnt == G_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt  <= '0;
            fall_cnt  <= '0;
            gap_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            port      <= 1'b0;
            ptr       <= 1'b0;
            resp_data <= '0;
            spi_sck   <= 1'b0;
            spi_ss    <= 1'b1;
            spi_mosi  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        tx_sr    <= {CMD_READ[6:0], grant ? req_addr1 : req_addr0};
                        port     <= grant;
                        half_cnt <= '0;
                        fall_cnt <= '0;
                        spi_ss   <= 1'b0;
                        spi_sck  <= 1'b0;
                        spi_mosi <= CMD_READ[7];
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        half_cnt <= '0;
                        spi_sck  <= ~spi_sck;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                    if (fall) begin
                        fall_cnt <= fall_cnt + 6'd1;
                        if (fall_cnt < LAST_TX) begin
                            spi_mosi <= tx_sr[30];
                            tx_sr    <= {tx_sr[29:0], 1'b0};
                        end else begin
                            spi_mosi <= 1'b0;
                            rx_sr    <= {rx_sr[29:0], spi_miso};
                        end
                    end
                    // final sample goes straight into the response word
                    if (last_fall) begin
                        resp_data <= {rx_sr, spi_miso};
                        spi_ss    <= 1'b1;
                    end
                end
                RESP: begin
                    ptr     <= ~port;
                    gap_cnt <= GW'(1);
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                    spi_ss  <= 1'b1;
                    spi_sck <= 1'b0;
                end
            endcase
        end
    end

endmodule
